// File: rtl/gin_pkg.sv
// -----------------------------------------------------------------------------
// gin_pkg
// Shared definitions for the gin multicast bus sequencer:
//   - default values for the sequencer parameters
//   - fixed counter widths (delivered-token counter, WAIT-state counter)
//   - FSM state encoding, also exported on the sequencer debug port
// -----------------------------------------------------------------------------
package gin_pkg;

  // Default parameter values for gin_sequencer.
  localparam int DEFAULT_BITWIDTH        = 16;
  localparam int DEFAULT_TAG_LENGTH      = 4;
  localparam int DEFAULT_NUM_CONTROLLERS = 10;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 255;

  // Delivered-token counter width; the counter wraps at 2**16.
  localparam int TX_COUNT_WIDTH = 16;

  // WAIT-state counter width; wide enough for the largest legal
  // TIMEOUT_CYCLES (65535).
  localparam int WAIT_CNT_WIDTH = 16;

  // Sequencer FSM states.
  //   IDLE : waiting for a program request or a data token
  //   PROG : shifting configuration tags into the controller scan chain
  //   SEND : broadcasting one token on the bus (single cycle)
  //   WAIT : waiting for every controller to report ready again
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/gin_wdt.sv
// -----------------------------------------------------------------------------
// gin_wdt
// Watchdog counter for the sequencer WAIT state.
//
// Ports:
//   clk      in   rising-edge clock
//   rstb     in   synchronous active-high reset
//   clear    in   force the count to zero (held while not waiting)
//   enable   in   count one cycle
//   expired  out  high in the last allowed counting cycle
//   count    out  current count (0 in the first counting cycle)
//
// The count is 0 in the first enabled cycle and rises by one per enabled
// cycle. expired is raised in the enabled cycle whose count is
// TIMEOUT_CYCLES-1, i.e. in the TIMEOUT_CYCLES-th counting cycle; the
// owner leaves the waiting state at the end of that cycle, which is the
// edge at which the count would have reached TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module gin_wdt
  import gin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      clear,
  input  logic                      enable,
  output logic                      expired,
  output logic [WAIT_CNT_WIDTH-1:0] count
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LAST_COUNT =
    WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rstb || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == LAST_COUNT);
  assign count   = cnt_q;

endmodule

// File: rtl/gin_sequencer.sv
// -----------------------------------------------------------------------------
// gin_sequencer
// Drives a multicast bus shared by NUM_CONTROLLERS controllers. It either
// programs the controllers' scan-tag chain (one tag per controller, shifted
// serially) or broadcasts data tokens and waits for every controller to
// become ready again before accepting the next one.
//
// Ports:
//   clk, rstb              clock (rising edge), synchronous active-high reset
//   prog_start             request to program the scan-tag chain (IDLE only)
//   cfg_valid/cfg_ready    configuration tag handshake, tag on cfg_tag
//   prog_done              one-cycle pulse with the last bus_program pulse
//   in_valid/in_ready      data token handshake, in_tag/in_data
//   bus_program            scan-chain shift enable (registered)
//   bus_scan_tag           scan-chain serial tag (registered)
//   bus_enable             token broadcast strobe (registered)
//   bus_tag, bus_data      broadcast tag/data (registered)
//   bus_ready              per-controller ready vector
//   busy                   FSM not in IDLE
//   err_timeout, err_clear sticky WAIT timeout flag and its clear
//   tx_count               delivered-token counter (wraps)
//   dbg_state              current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its payload stable while valid is high and
// not yet accepted; ready never depends on valid.
//
// Scan-chain order: tags are shifted toward the far end of the chain, so
// the first accepted tag belongs to controller NUM_CONTROLLERS-1 and the
// last one to controller 0. The sequencer shifts tags in arrival order;
// the upstream source supplies them farthest-first.
// -----------------------------------------------------------------------------
module gin_sequencer
  import gin_pkg::*;
#(
  parameter int BITWIDTH        = DEFAULT_BITWIDTH,
  parameter int TAG_LENGTH      = DEFAULT_TAG_LENGTH,
  parameter int NUM_CONTROLLERS = DEFAULT_NUM_CONTROLLERS,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       prog_start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [TAG_LENGTH-1:0]      cfg_tag,
  output logic                       prog_done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_LENGTH-1:0]      in_tag,
  input  logic [BITWIDTH-1:0]        in_data,
  output logic                       bus_program,
  output logic [TAG_LENGTH-1:0]      bus_scan_tag,
  output logic                       bus_enable,
  output logic [TAG_LENGTH-1:0]      bus_tag,
  output logic [BITWIDTH-1:0]        bus_data,
  input  logic [NUM_CONTROLLERS-1:0] bus_ready,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clear,
  output logic [TX_COUNT_WIDTH-1:0]  tx_count,
  output state_t                     dbg_state
);

  // Handshake counter during PROG; one extra bit keeps NUM_CONTROLLERS=1 legal.
  localparam int PCW = $clog2(NUM_CONTROLLERS + 1);
  localparam logic [PCW-1:0] LAST_CFG = PCW'(NUM_CONTROLLERS - 1);

  state_t state, state_next;

  logic                      ready_all;
  logic                      cfg_hs;
  logic                      in_hs;
  logic                      prog_last;
  logic                      wait_done;
  logic                      wait_to;
  logic                      wait_clear;
  logic                      wait_en;
  logic                      wdt_expired;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

  logic [PCW-1:0]            prog_cnt_q;
  logic                      bus_program_q;
  logic [TAG_LENGTH-1:0]     scan_tag_q;
  logic                      bus_enable_q;
  logic [TAG_LENGTH-1:0]     tag_q;
  logic [BITWIDTH-1:0]       data_q;
  logic                      prog_done_q;
  logic                      err_q;
  logic [TX_COUNT_WIDTH-1:0] tx_count_q;

  // ---------------------------------------------------------------------------
  // Handshake and exit conditions
  // ---------------------------------------------------------------------------
  assign ready_all = &bus_ready;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign in_hs     = in_valid && in_ready;
  assign prog_last = cfg_hs && (prog_cnt_q == LAST_CFG);

  // wait_cnt is 0 in the first WAIT cycle, so a controller ready vector
  // that never dropped still costs one full WAIT cycle before release.
  assign wait_done = (state == WAIT) && ready_all && (wait_cnt != '0);

  // A normal release in the expiry cycle takes precedence over the timeout.
  assign wait_to   = wdt_expired && !wait_done;

  // ---------------------------------------------------------------------------
  // WAIT-state watchdog
  // ---------------------------------------------------------------------------
  gin_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rstb    (rstb),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wdt_expired),
    .count   (wait_cnt)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // prog_start wins over a pending token; in_hs is already masked by it.
        if (prog_start) begin
          state_next = PROG;
        end else if (in_hs) begin
          state_next = SEND;
        end
      end
      PROG: begin
        if (prog_last) begin
          state_next = IDLE;
        end
      end
      SEND: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_done || wait_to) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_ready  = (state == PROG);
    in_ready   = (state == IDLE) && ready_all && !prog_start;
    busy       = (state != IDLE);
    wait_en    = (state == WAIT);
    wait_clear = (state != WAIT);
  end

  // ---------------------------------------------------------------------------
  // Registered bus outputs, counters and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstb) begin
      prog_cnt_q    <= '0;
      bus_program_q <= 1'b0;
      scan_tag_q    <= '0;
      bus_enable_q  <= 1'b0;
      tag_q         <= '0;
      data_q        <= '0;
      prog_done_q   <= 1'b0;
      err_q         <= 1'b0;
      tx_count_q    <= '0;
    end else begin
      // Count configuration handshakes only while programming.
      if (state != PROG) begin
        prog_cnt_q <= '0;
      end else if (cfg_hs) begin
        prog_cnt_q <= prog_cnt_q + 1'b1;
      end

      // One shift pulse per accepted tag; without a handshake the chain holds.
      bus_program_q <= cfg_hs;
      if (cfg_hs) begin
        scan_tag_q <= cfg_tag;
      end
      prog_done_q <= prog_last;

      // in_hs only occurs in IDLE, so this strobe lines up with SEND.
      bus_enable_q <= in_hs;
      if (in_hs) begin
        tag_q  <= in_tag;
        data_q <= in_data;
      end

      if (wait_done) begin
        tx_count_q <= tx_count_q + 1'b1;
      end

      // A timeout in the same cycle as err_clear leaves the flag set.
      if (wait_to) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus_program  = bus_program_q;
  assign bus_scan_tag = scan_tag_q;
  assign bus_enable   = bus_enable_q;
  assign bus_tag      = tag_q;
  assign bus_data     = data_q;
  assign prog_done    = prog_done_q;
  assign err_timeout  = err_q;
  assign tx_count     = tx_count_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_gin_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gin_sequencer
// Self-checking bench for gin_sequencer (TIMEOUT_CYCLES = 8).
// Expected scan tags and bus words are queued when the bench sees its own
// handshake accepted, and popped by a negedge monitor when the bus shows
// them. Token timing, tx_count and err_timeout come from a small model.
// -----------------------------------------------------------------------------
module tb_gin_sequencer;
  import gin_pkg::*;

  localparam int BW = 16;
  localparam int TL = 4;
  localparam int NC = 10;
  localparam int TO = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rstb;
  logic          prog_start;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [TL-1:0] cfg_tag;
  logic          prog_done;
  logic          in_valid;
  logic          in_ready;
  logic [TL-1:0] in_tag;
  logic [BW-1:0] in_data;
  logic          bus_program;
  logic [TL-1:0] bus_scan_tag;
  logic          bus_enable;
  logic [TL-1:0] bus_tag;
  logic [BW-1:0] bus_data;
  logic [NC-1:0] bus_ready;
  logic          busy;
  logic          err_timeout;
  logic          err_clear;
  logic [15:0]   tx_count;
  state_t        dbg_state;

  always #5 clk = ~clk;

  gin_sequencer #(
    .BITWIDTH        (BW),
    .TAG_LENGTH      (TL),
    .NUM_CONTROLLERS (NC),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .prog_start   (prog_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_tag      (cfg_tag),
    .prog_done    (prog_done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tag       (in_tag),
    .in_data      (in_data),
    .bus_program  (bus_program),
    .bus_scan_tag (bus_scan_tag),
    .bus_enable   (bus_enable),
    .bus_tag      (bus_tag),
    .bus_data     (bus_data),
    .bus_ready    (bus_ready),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_clear    (err_clear),
    .tx_count     (tx_count),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [TL-1:0]    exp_scan_q[$];
  logic [TL+BW-1:0] exp_tok_q[$];
  logic [15:0]   exp_tx;
  logic          exp_err;
  int            pulses;
  int            done_cnt;
  bit            mon_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("bus_exclusive", 32'(bus_enable & bus_program), 32'd0);
      // The bench always holds cfg_valid, so program pulses must be back to back.
      if (pulses != 0 || bus_program) check("prog_consecutive", 32'(bus_program), 32'd1);
      if (bus_program) begin
        if (exp_scan_q.size() == 0) check("scan_unexpected", 32'(bus_program), 32'd0);
        else check("scan_tag", 32'(bus_scan_tag), 32'(exp_scan_q.pop_front()));
        pulses++;
      end
      check("prog_done", 32'(prog_done), 32'(bus_program && (pulses == NC)));
      if (pulses == NC) begin
        done_cnt++;
        pulses = 0;
      end
      if (bus_enable) begin
        if (exp_tok_q.size() == 0) check("enable_unexpected", 32'(bus_enable), 32'd0);
        else check("bus_word", 32'({bus_tag, bus_data}), 32'(exp_tok_q.pop_front()));
      end
      if (rstb) pulses = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_program"},  32'(bus_program),  32'd0);
    check({tag, "_bus_scan_tag"}, 32'(bus_scan_tag), 32'd0);
    check({tag, "_bus_enable"},   32'(bus_enable),   32'd0);
    check({tag, "_bus_tag"},      32'(bus_tag),      32'd0);
    check({tag, "_bus_data"},     32'(bus_data),     32'd0);
    check({tag, "_prog_done"},    32'(prog_done),    32'd0);
    check({tag, "_busy"},         32'(busy),         32'd0);
    check({tag, "_cfg_ready"},    32'(cfg_ready),    32'd0);
    check({tag, "_tx_count"},     32'(tx_count),     32'd0);
    check({tag, "_err_timeout"},  32'(err_timeout),  32'd0);
    check({tag, "_state"},        32'(dbg_state),    32'(IDLE));
  endtask

  // Request programming and feed n_tags tags, farthest controller first.
  task automatic program_chain(input int n_tags);
    bit acc;
    prog_start = 1'b1;
    @(negedge clk);
    check("in_ready_with_prog_start", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    prog_start = 1'b0;
    check("busy_in_prog", 32'(busy), 32'd1);
    cfg_valid = 1'b1;
    for (int k = 0; k < n_tags; k++) begin
      cfg_tag = TL'(NC - 1 - k);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        @(negedge clk);
        if (cfg_ready) begin
          exp_scan_q.push_back(cfg_tag);
          acc = 1'b1;
        end
        @(posedge clk); #1;
      end
      check("cfg_handshake", 32'(acc), 32'd1);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic expect_done(input int d0);
    @(negedge clk);
    @(posedge clk); #1;
    check("prog_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("idle_after_prog", 32'(busy), 32'd0);
    check("cfg_ready_after_prog", 32'(cfg_ready), 32'd0);
  endtask

  // Send one token. Controllers in drop_mask go not-ready in the SEND cycle
  // and come back at the negedge of busy cycle 'low'; expect_to means they
  // never come back before the watchdog fires.
  task automatic send_token(input logic [TL-1:0] t, input logic [BW-1:0] d,
                            input logic [NC-1:0] drop_mask, input int low,
                            input bit expect_to);
    bit acc;
    bit done;
    int bc;
    acc  = 1'b0;
    done = 1'b0;
    bc   = 0;
    in_valid = 1'b1;
    in_tag   = t;
    in_data  = d;
    for (int w = 0; w < 100 && !acc; w++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_tok_q.push_back({t, d});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_handshake", 32'(acc), 32'd1);
    if (acc) begin
      if (drop_mask != '0) bus_ready = ~drop_mask;
      for (int w = 0; w < 300 && !done; w++) begin
        @(negedge clk);
        if (!busy) done = 1'b1;
        else begin
          bc++;
          if (bc == low) bus_ready = '1;
        end
      end
      bus_ready = '1;
      check("busy_bounded", 32'(done), 32'd1);
      if (expect_to) begin
        check("timeout_cycles", 32'(bc), 32'(TO + 1));
        exp_err = 1'b1;
      end else begin
        check("busy_cycles", 32'(bc), 32'((drop_mask != '0 && low > 3) ? low : 3));
        exp_tx++;
      end
      check("tx_count", 32'(tx_count), 32'(exp_tx));
      check("err_timeout", 32'(err_timeout), 32'(exp_err));
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [TL-1:0] rt;
    logic [BW-1:0] rd;
    logic [NC-1:0] rm;
    int            rl;
    int            d0;

    rstb = 1'b1; prog_start = 1'b0; cfg_valid = 1'b0; cfg_tag = '0;
    in_valid = 1'b0; in_tag = '0; in_data = '0; bus_ready = '0; err_clear = 1'b0;
    exp_tx = '0; exp_err = 1'b0; pulses = 0; done_cnt = 0; mon_en = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    check("por_in_ready", 32'(in_ready), 32'd0);
    rstb = 1'b0;
    mon_en = 1'b1;
    bus_ready = '1;
    @(posedge clk); #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);

    // Full scan-chain program, tags 9..0
    d0 = done_cnt;
    program_chain(NC);
    expect_done(d0);

    // Directed token: all controllers drop in SEND, return after 4 cycles
    send_token(4'd3, 16'hBEEF, '1, 4, 1'b0);
    check("tx_after_first", 32'(tx_count), 32'd1);

    // Random tokens with random single-controller stalls
    for (int i = 0; i < 4; i++) begin
      rt = TL'($urandom_range(0, 15));
      rd = BW'($urandom_range(0, 65535));
      rl = int'($urandom_range(0, 6));
      rm = (rl == 0) ? '0 : (NC'(1) << $urandom_range(0, NC - 1));
      send_token(rt, rd, rm, rl, 1'b0);
    end

    // Controller 5 never returns: watchdog timeout
    send_token(4'd9, 16'h0F0F, NC'(1) << 5, 1000, 1'b1);

    // The error flag does not block delivery
    send_token(4'd1, 16'h5A5A, '0, 0, 1'b0);

    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", 32'(err_timeout), 32'(exp_err));

    // Timeout while err_clear is held: setting wins in the same cycle
    err_clear = 1'b1;
    send_token(4'd2, 16'h1357, NC'(1) << 5, 1000, 1'b1);
    err_clear = 1'b0;
    exp_err = 1'b0;
    check("err_cleared_after_set", 32'(err_timeout), 32'(exp_err));

    // prog_start and in_valid together: program first, token afterwards
    in_valid = 1'b1;
    in_tag   = 4'd7;
    in_data  = 16'h1234;
    d0 = done_cnt;
    program_chain(NC);
    send_token(4'd7, 16'h1234, '0, 0, 1'b0);
    check("prog_before_token", 32'(done_cnt), 32'(d0 + 1));

    // Reset after 4 of 10 tags abandons the program
    d0 = done_cnt;
    program_chain(4);
    rstb = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0;
    exp_tx = '0;
    exp_err = 1'b0;
    check_reset_outputs("abort");
    @(negedge clk);
    @(posedge clk); #1;
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_scan_q", 32'(exp_scan_q.size()), 32'd0);

    d0 = done_cnt;
    program_chain(NC);
    expect_done(d0);

    // tx_count wraps from 65535 to 0
    force dut.tx_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.tx_count_q;
    exp_tx = 16'hFFFF;
    check("tx_preload", 32'(tx_count), 32'(exp_tx));
    send_token(4'd4, 16'hCAFE, '1, 2, 1'b0);
    check("tx_wrapped", 32'(tx_count), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scan_q_drained", 32'(exp_scan_q.size()), 32'd0);
    check("tok_q_drained", 32'(exp_tok_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/gin_sequencer.md
GIN_SEQUENCER -- requirements
Module: gin_sequencer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, data word width.
REQ-002 SHALL have parameter TAG_LENGTH, default 4, tag / scan-tag width.
REQ-003 SHALL have parameter NUM_CONTROLLERS, default 10, multicast controllers on the bus.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles (range 2..65535).
REQ-005 SHALL have the following ports; one clock, reset synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rstb  in  1  synchronous active-high reset.
- prog_start  in  1  request to program the scan-tag chain.
- cfg_valid  in  1  configuration tag available.
- cfg_ready  out  1  configuration tag accepted when both are high.
- cfg_tag  in  TAG_LENGTH  tag for one controller.
- prog_done  out  1  one-cycle pulse after the last tag has shifted.
- in_valid  in  1  data token available.
- in_ready  out  1  token accepted when both are high.
- in_tag  in  TAG_LENGTH  destination tag.
- in_data  in  BITWIDTH  payload.
- bus_program  out  1  scan-chain shift enable.
- bus_scan_tag  out  TAG_LENGTH  scan-chain serial tag.
- bus_enable  out  1  bus controller enable.
- bus_tag  out  TAG_LENGTH  broadcast tag.
- bus_data  out  BITWIDTH  broadcast data.
- bus_ready  in  NUM_CONTROLLERS  per-controller ready vector.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky timeout flag.
- err_clear  in  1  clears err_timeout.
- tx_count  out  16  delivered-token counter.

Function
REQ-006 SHALL implement FSM states IDLE, PROG, SEND, WAIT; all bus_* outputs SHALL be registered.
REQ-007 IDLE, prog_start=1 -> PROG next cycle; prog_start SHALL take priority over in_valid; prog_start outside IDLE SHALL be ignored.
REQ-008 in_ready SHALL equal (state==IDLE) & all bits of bus_ready high & ~prog_start, combinationally.
REQ-009 On in_valid&in_ready, SHALL latch in_tag/in_data and enter SEND; in SEND, bus_enable=1 with the latched bus_tag/bus_data, for exactly one cycle.
REQ-010 SEND -> WAIT unconditionally; on entry to WAIT, wait_cnt SHALL be 0 and then increment every cycle.
REQ-011 WAIT -> IDLE when all bus_ready are high and wait_cnt != 0; tx_count SHALL then increment by 1, wrapping from 65535 to 0.
REQ-012 If wait_cnt reaches TIMEOUT_CYCLES without the REQ-011 exit, SHALL set err_timeout=1 and go to IDLE; tx_count SHALL be unchanged.
REQ-013 err_clear=1 SHALL clear err_timeout next cycle; if set and clear occur in the same cycle, set SHALL win. err_timeout SHALL NOT block operation.
REQ-014 In PROG, cfg_ready=1; each cfg handshake SHALL drive bus_program=1 with bus_scan_tag=cfg_tag in the following cycle. Cycles without a handshake SHALL drive bus_program=0 (chain holds).
REQ-015 The first accepted tag SHALL be the one for the farthest controller (index NUM_CONTROLLERS-1); the tag for controller 0 SHALL be last.
REQ-016 After exactly NUM_CONTROLLERS handshakes: cfg_ready=0, return to IDLE, and prog_done=1 in the cycle the last bus_program pulse is driven.
REQ-017 bus_enable and bus_program SHALL never be high in the same cycle.
REQ-018 busy SHALL be 1 in PROG, SEND and WAIT.

Reset
REQ-019 rstb=1 at a clock edge SHALL force IDLE, set all outputs and counters to 0 (including tx_count and err_timeout), and clear the latched tag/data.
REQ-020 Reset during PROG SHALL abandon the partial program with no prog_done pulse; reset during SEND/WAIT SHALL deassert bus_enable next edge, with no tx_count increment.

Structure
REQ-021 A shared package gin_pkg SHALL hold the FSM state encoding and the default parameter constants (BITWIDTH, TAG_LENGTH, NUM_CONTROLLERS, TIMEOUT_CYCLES).
REQ-022 The timeout counter SHALL be a sub-module gin_wdt (clear, enable, expired); everything else SHALL be in gin_sequencer.

Verification
REQ-023 Program: prog_start, then 10 tags 9..0 with cfg_valid held high -> 10 consecutive bus_program pulses, scan tags 9..0, prog_done coincident with the last pulse.
REQ-024 Token: all ready, in_tag=3, in_data=16'hBEEF -> bus_enable for one cycle with tag 3 / BEEF; bus_ready drops and then rises after 4 cycles -> IDLE, tx_count=1.
REQ-025 Timeout: TIMEOUT_CYCLES=8, bus_ready[5] held low after SEND -> err_timeout=1 after 8 WAIT cycles, tx_count unchanged; err_clear -> 0.
REQ-026 Priority: prog_start and in_valid asserted together in IDLE -> in_ready=0, PROG entered, token accepted after prog_done.
REQ-027 Reset: rstb after 4 of 10 cfg tags -> all outputs 0, no prog_done; a full 10-tag program afterwards succeeds.
REQ-028 Wrap: preload tx_count by force to 65535, deliver one token -> tx_count=0.
